clk_tick_gen: RTL

//  Parametrised multi-channel timebase generator from one source clock.

---
 rtl/clk_tick_pkg.sv | 18 +
 rtl/clk_tick_chan.sv | 71 +++++++
 rtl/clk_tick_gen.sv | 50 +++++
 3 files changed

// File: rtl/clk_tick_pkg.sv
// clk_tick_pkg: shared constants and helpers for the timebase generator.
//   CLK_HZ     source clock frequency
//   DIV_*      named divisors for the timer top level
//   div_clamp  effective divisor, max(d, 2)
package clk_tick_pkg;

  localparam int unsigned CLK_HZ   = 100_000_000;
  localparam int unsigned DIV_1HZ  = CLK_HZ;
  localparam int unsigned DIV_2HZ  = CLK_HZ / 2;  // blink
  localparam int unsigned DIV_4HZ  = CLK_HZ / 4;  // long-press
  localparam int unsigned DIV_SCAN = 4096;

  // Divisors 0 and 1 cannot produce a period, so they behave as 2.
  function automatic logic [31:0] div_clamp(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

endpackage

// File: rtl/clk_tick_chan.sv
// clk_tick_chan: one timebase channel.
//   clk_sourecs  system clock
//   rest         synchronous active-high reset
//   run          1 = count, 0 = freeze (cnt/level hold, tick low)
//   sync_clr     restart the channel at cnt 0 with the shadow divisor
//   div_we       write strobe for this channel's shadow divisor
//   div_val      new divisor value
//   tick         registered one-cycle strobe at the end of each period
//   level        registered square wave, low floor(D/2), high ceil(D/2)
module clk_tick_chan
  import clk_tick_pkg::*;
#(
  parameter int unsigned      CNT_W   = 27,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_1HZ)
) (
  input  logic             clk_sourecs,
  input  logic             rest,
  input  logic             run,
  input  logic             sync_clr,
  input  logic             div_we,
  input  logic [CNT_W-1:0] div_val,
  output logic             tick,
  output logic             level
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] shadow_div;
  logic [CNT_W-1:0] d_eff;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] shadow_in;
  logic             wrap;

  always_comb begin
    d_eff     = CNT_W'(div_clamp(32'(active_div)));
    half      = d_eff >> 1;
    wrap      = (cnt == d_eff - CNT_W'(1));
    // A write in the same cycle as a load is forwarded so the write wins.
    shadow_in = div_we ? div_val : shadow_div;
  end

  always_ff @(posedge clk_sourecs) begin
    if (rest) begin
      cnt        <= '0;
      active_div <= DIV_RST;
      shadow_div <= DIV_RST;
      tick       <= 1'b0;
      level      <= 1'b0;
    end else begin
      shadow_div <= shadow_in;
      if (sync_clr) begin
        cnt        <= '0;
        active_div <= shadow_in;
        tick       <= 1'b0;
        level      <= 1'b0;
      end else if (run) begin
        tick  <= wrap;
        level <= (cnt >= half);
        if (wrap) begin
          cnt        <= '0;
          active_div <= shadow_in;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel timebase generator from one source clock.
//   clk_sourecs  system clock, all logic on rising edge
//   rest         synchronous active-high reset
//   run          1 = counters advance, 0 = freeze
//   sync_clr     restart all channels together
//   div_we       divisor shadow write strobe
//   div_sel      channel index for div_we (out-of-range ignored)
//   div_val      new divisor (period in clk_sourecs cycles)
//   tick         per-channel registered one-cycle strobe per period
//   level        per-channel registered square wave
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int unsigned           N_CH     = 4,
  parameter int unsigned           CNT_W    = 27,
  parameter logic [N_CH*CNT_W-1:0] DIV_INIT = {N_CH{CNT_W'(DIV_1HZ)}}
) (
  input  logic             clk_sourecs,
  input  logic             rest,
  input  logic             run,
  input  logic             sync_clr,
  input  logic             div_we,
  input  logic [2:0]       div_sel,
  input  logic [CNT_W-1:0] div_val,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  level
);

  logic [N_CH-1:0] chan_we;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    // Indices at or above N_CH never match, so such writes are dropped.
    assign chan_we[i] = div_we && (div_sel == 3'(i));

    clk_tick_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk_sourecs (clk_sourecs),
      .rest        (rest),
      .run         (run),
      .sync_clr    (sync_clr),
      .div_we      (chan_we[i]),
      .div_val     (div_val),
      .tick        (tick[i]),
      .level       (level[i])
    );
  end

endmodule
